// File: rtl/move_collector.sv
`default_nettype none
// ============================================================================
//  Module      : move_collector
//  Description : Drains the per-square move FIFOs once every square unit has
//                finished generating. Each 152-bit FIFO word is unpacked into
//                eight 19-bit move slots, examined slot 7 down to slot 0.
//                Valid moves are streamed over a valid/ready interface.
//                Emitted moves are counted up to MAXMOVES. A valid move that
//                arrives once the count is full is dropped, and this sets a
//                sticky overflow flag.
//  Option      : define MVC_CAPTURE_STATS_EN to add the capCount output,
//                a saturating count of accepted capture moves.
//  Revision    : 1.0  initial release
// ============================================================================
module move_collector #(
  parameter int NSRC     = 64,
  parameter int MAXMOVES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NSRC-1:0]        sqDone,
  input  logic [NSRC-1:0]        sqEmpty,
  input  logic [NSRC*152-1:0]    sqData,
  output logic [NSRC-1:0]        sqRden,
  output logic                   mvValid,
  output logic [18:0]            mvData,
  input  logic                   mvReady,
  output logic [7:0]             mvCount,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
`ifdef MVC_CAPTURE_STATS_EN
  ,
  output logic [7:0]             capCount
`endif
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_WORD_W = 152;
  localparam int c_MOVE_W = 19;
  localparam int c_SLOTS  = 8;
  localparam int c_IDX_W  = (NSRC > 1) ? $clog2(NSRC) : 1;

  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NSRC - 1);
  localparam logic [7:0]         c_MAX      = 8'(MAXMOVES);
  localparam logic [2:0]         c_TOP_SLOT = 3'd7;

  // Move word flag bit positions
  localparam int c_BIT_INVALID = 18;
  localparam int c_BIT_CAPTURE = 12;

  // State encoding
  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_WAIT = 3'd1;
  localparam logic [2:0] c_ST_SCAN = 3'd2;
  localparam logic [2:0] c_ST_LAT  = 3'd3;
  localparam logic [2:0] c_ST_EMIT = 3'd4;
  localparam logic [2:0] c_ST_DONE = 3'd5;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]          r_state;
  logic [c_IDX_W-1:0]  r_idx;
  logic [2:0]          r_slot;
  logic [c_WORD_W-1:0] r_word;
  logic [7:0]          r_count;
  logic                r_overflow;

  // --------------------------------------------------------------------------
  // Combinational views
  // --------------------------------------------------------------------------
  logic [c_WORD_W-1:0] w_src_word  [NSRC];
  logic [c_MOVE_W-1:0] w_slot_word [c_SLOTS];
  logic [c_MOVE_W-1:0] w_cur_move;
  logic                w_in_scan;
  logic                w_in_emit;
  logic                w_cur_invalid;
  logic                w_room;
  logic                w_emit_valid;
  logic                w_accept;
  logic                w_drop;
  logic                w_slot_done;
  logic                w_src_has_word;
  logic                w_pass_start;

  genvar gi;
  generate
    // Per-square view of the flat FIFO q bus
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      assign w_src_word[gi] = sqData[gi*c_WORD_W +: c_WORD_W];
    end
    // Per-slot view of the latched FIFO word
    for (gi = 0; gi < c_SLOTS; gi++) begin : g_slot
      assign w_slot_word[gi] = r_word[gi*c_MOVE_W +: c_MOVE_W];
    end
  endgenerate

  assign w_in_scan      = (r_state == c_ST_SCAN);
  assign w_in_emit      = (r_state == c_ST_EMIT);
  assign w_cur_move     = w_slot_word[r_slot];
  assign w_cur_invalid  = w_cur_move[c_BIT_INVALID];
  assign w_room         = (r_count < c_MAX);
  assign w_src_has_word = ~sqEmpty[r_idx];

  // A valid slot is offered only while there is room left in the count.
  assign w_emit_valid   = w_in_emit & ~w_cur_invalid & w_room;
  assign w_accept       = w_emit_valid & mvReady;
  assign w_drop         = w_in_emit & ~w_cur_invalid & ~w_room;

  // A slot is finished when it is skipped, dropped, or handed over.
  assign w_slot_done    = w_in_emit & (w_cur_invalid | ~w_room | mvReady);

  // start is honoured only from the two resting states.
  assign w_pass_start   = start & ((r_state == c_ST_IDLE) | (r_state == c_ST_DONE));

  // --------------------------------------------------------------------------
  // Main sequencer: wait for all squares, scan, latch a word, walk its slots
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_ST_IDLE;
      r_idx      <= '0;
      r_slot     <= c_TOP_SLOT;
      r_word     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE, c_ST_DONE: begin
          if (w_pass_start) begin
            r_state    <= c_ST_WAIT;
            r_idx      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
          end
        end

        c_ST_WAIT: begin
          if (&sqDone) begin
            r_state <= c_ST_SCAN;
          end
        end

        c_ST_SCAN: begin
          if (w_src_has_word) begin
            r_state <= c_ST_LAT;
          end else if (r_idx == c_LAST_IDX) begin
            r_state <= c_ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        c_ST_LAT: begin
          // FIFO q becomes valid the cycle after the read request.
          r_word  <= w_src_word[r_idx];
          r_slot  <= c_TOP_SLOT;
          r_state <= c_ST_EMIT;
        end

        c_ST_EMIT: begin
          if (w_accept) begin
            r_count <= r_count + 8'd1;
          end
          if (w_drop) begin
            r_overflow <= 1'b1;
          end
          if (w_slot_done) begin
            if (r_slot == 3'd0) begin
              // Revisit the same square so all of its words drain first.
              r_state <= c_ST_SCAN;
            end else begin
              r_slot <= r_slot - 3'd1;
            end
          end
        end

        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FIFO read request: one-hot on the scanned square, only while scanning
  // --------------------------------------------------------------------------
  always_comb begin
    sqRden = '0;
    if (w_in_scan && w_src_has_word) begin
      sqRden[r_idx] = 1'b1;
    end
  end

`ifdef MVC_CAPTURE_STATS_EN
  logic [7:0] r_cap_count;

  // Count accepted capture moves, saturating, cleared along with the pass
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cap_count <= '0;
    end else if (w_pass_start) begin
      r_cap_count <= '0;
    end else if (w_accept && w_cur_move[c_BIT_CAPTURE] && (r_cap_count != 8'hFF)) begin
      r_cap_count <= r_cap_count + 8'd1;
    end
  end

  assign capCount = r_cap_count;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mvValid  = w_emit_valid;
  assign mvData   = w_emit_valid ? w_cur_move : '0;
  assign mvCount  = r_count;
  assign overflow = r_overflow;
  assign busy     = (r_state != c_ST_IDLE) && (r_state != c_ST_DONE);
  assign done     = (r_state == c_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_move_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_move_collector
//  Description : Self-checking bench for move_collector. It emulates the
//                square FIFOs with queues. Expected move streams come from a
//                behavioural model of the collection rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_move_collector;

  localparam int NSRC   = 64;
  localparam int MAXM   = 255;
  localparam int LIMIT  = 20000;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [NSRC-1:0]      sq_done;
  logic [NSRC-1:0]      sq_empty;
  logic [NSRC*152-1:0]  sq_data;
  logic [NSRC-1:0]      sqRden;
  logic                 mvValid;
  logic [18:0]          mvData;
  logic                 mvReady;
  logic [7:0]           mvCount;
  logic                 busy;
  logic                 done;
  logic                 overflow;
`ifdef MVC_CAPTURE_STATS_EN
  logic [7:0]           capCount;
`endif

  move_collector #(.NSRC(NSRC), .MAXMOVES(MAXM)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sqDone   (sq_done),
    .sqEmpty  (sq_empty),
    .sqData   (sq_data),
    .sqRden   (sqRden),
    .mvValid  (mvValid),
    .mvData   (mvData),
    .mvReady  (mvReady),
    .mvCount  (mvCount),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
`ifdef MVC_CAPTURE_STATS_EN
    ,
    .capCount (capCount)
`endif
  );

  always #5 clk = ~clk;

  // Bench state
  int          errors = 0;
  int          checks = 0;
  int          beats  = 0;
  int          pops   = 0;
  int          stall_left = 0;
  bit          rdy_rand = 1'b0;
  logic [151:0] fifo [NSRC][$];
  logic [18:0]  exp_q[$];
  int          exp_cnt, exp_cap, exp_words;
  bit          exp_ovf;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Random move word: slots whose mask bit is set are valid.
  function automatic logic [151:0] gen_word(input logic [7:0] mask);
    logic [151:0] w;
    logic [18:0]  mv;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      mv     = 19'($urandom());
      mv[18] = ~mask[k];
      w[k*19 +: 19] = mv;
    end
    return w;
  endfunction

  task automatic clear_fifos();
    for (int i = 0; i < NSRC; i++) fifo[i].delete();
  endtask

  // Reference: squares in order, words in FIFO order, slots 7..0,
  // invalid skipped, valid ones emitted until MAXM then dropped.
  task automatic build_model();
    logic [151:0] w;
    logic [18:0]  mv;
    exp_q.delete();
    exp_cnt = 0; exp_cap = 0; exp_words = 0; exp_ovf = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      for (int n = 0; n < fifo[i].size(); n++) begin
        w = fifo[i][n];
        exp_words++;
        for (int k = 7; k >= 0; k--) begin
          mv = w[k*19 +: 19];
          if (!mv[18]) begin
            if (exp_cnt < MAXM) begin
              exp_q.push_back(mv);
              exp_cnt++;
              if (mv[12] && exp_cap < 255) exp_cap++;
            end else begin
              exp_ovf = 1'b1;
            end
          end
        end
      end
    end
  endtask

  // FIFO emulation: a read request seen during a cycle pops into q after the edge.
  initial begin
    logic [NSRC-1:0] pend;
    sq_data  = '0;
    sq_empty = '1;
    forever begin
      @(negedge clk);
      pend = sqRden;
      @(posedge clk);
      #1;
      for (int i = 0; i < NSRC; i++) begin
        if (pend[i] && fifo[i].size() > 0) begin
          sq_data[i*152 +: 152] = fifo[i].pop_front();
          pops++;
        end
      end
      for (int i = 0; i < NSRC; i++) sq_empty[i] = (fifo[i].size() == 0);
    end
  end

  // Consumer ready: forced stalls, random back-pressure, or always ready.
  initial begin
    mvReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && mvValid) begin
        mvReady = 1'b0;
        stall_left--;
      end else if (rdy_rand) begin
        mvReady = ($urandom_range(0, 3) != 0);
      end else begin
        mvReady = 1'b1;
      end
    end
  end

  // Stream monitor: scoreboard accepted beats and check interface rules.
  initial begin
    bit          prev_hold = 1'b0;
    logic [18:0] prev_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_hold = 1'b0;
      end else begin
        check("rden_onehot0", 32'($onehot0(sqRden)), 32'd1);
        if (!mvValid) check("data_zero_idle", 32'(mvData), 32'd0);
        if (prev_hold) begin
          check("hold_valid", 32'(mvValid), 32'd1);
          check("hold_data", 32'(mvData), 32'(prev_data));
        end
        if (mvValid && mvReady) begin
          beats++;
          check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) check("mv_data", 32'(mvData), 32'(exp_q.pop_front()));
        end
        prev_hold = mvValid && !mvReady;
        prev_data = mvData;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rden"},  32'(sqRden != '0), 32'd0);
    check({tag, "_valid"}, 32'(mvValid), 32'd0);
    check({tag, "_data"},  32'(mvData), 32'd0);
    check({tag, "_count"}, 32'(mvCount), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_ovf"},   32'(overflow), 32'd0);
`ifdef MVC_CAPTURE_STATS_EN
    check({tag, "_cap"},   32'(capCount), 32'd0);
`endif
  endtask

  // Run one collection pass over the current FIFO contents and check the result.
  task automatic run_pass(input string tag, input bit gate);
    int cyc;
    build_model();
    beats = 0;
    pops  = 0;
    sq_done = gate ? ~{{(NSRC-1){1'b0}}, 1'b1} : '1;
    repeat (2) @(posedge clk);
    #1; start = 1'b1;
    @(posedge clk);
    #1; start = 1'b0;
    if (gate) begin
      repeat (4) @(negedge clk);
      check({tag, "_wait_busy"}, 32'(busy), 32'd1);
      check({tag, "_wait_rden"}, 32'(sqRden != '0), 32'd0);
      check({tag, "_wait_done"}, 32'(done), 32'd0);
      @(posedge clk);
      #1; sq_done = '1;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_scan_rden0"}, 32'(sqRden[0]), 32'(fifo[0].size() > 0));
    end
    cyc = 0;
    while (!done && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_reach_done"}, 32'(done), 32'd1);
    @(negedge clk);
    check({tag, "_count"}, 32'(mvCount), 32'(exp_cnt));
    check({tag, "_ovf"},   32'(overflow), 32'(exp_ovf));
    check({tag, "_beats"}, 32'(beats), 32'(exp_cnt));
    check({tag, "_left"},  32'(exp_q.size()), 32'd0);
    check({tag, "_pops"},  32'(pops), 32'(exp_words));
    check({tag, "_busy"},  32'(busy), 32'd0);
`ifdef MVC_CAPTURE_STATS_EN
    check({tag, "_cap"},   32'(capCount), 32'(exp_cap));
`endif
  endtask

  initial begin
    logic [151:0] w;
    int cyc;
    reset   = 1'b1;
    start   = 1'b0;
    sq_done = '1;
    clear_fifos();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    #1; reset = 1'b0;

    // Single move on square 12, slot 3
    clear_fifos();
    w = gen_word(8'h00);
    w[3*19 +: 19] = 19'h00A1C;
    fifo[12].push_back(w);
    run_pass("single", 1'b0);

    // Back-pressure on the first two valid slots of square 0
    clear_fifos();
    fifo[0].push_back(gen_word(8'b1010_0000));
    stall_left = 4;
    run_pass("bpress", 1'b0);

    // Two full words on the last square
    clear_fifos();
    fifo[63].push_back(gen_word(8'hFF));
    fifo[63].push_back(gen_word(8'hFF));
    run_pass("multi", 1'b0);

    // WAIT gating, plus an all-invalid word on square 1
    clear_fifos();
    fifo[0].push_back(gen_word(8'h5A));
    fifo[1].push_back(gen_word(8'h00));
    fifo[40].push_back(gen_word(8'h81));
    run_pass("gate", 1'b1);

    // Three capture-flagged moves mixed with one quiet move
    clear_fifos();
    w = gen_word(8'h00);
    w[6*19 +: 19] = {1'b0, 6'b000001, 12'($urandom())};
    w[4*19 +: 19] = {1'b0, 6'b100001, 12'($urandom())};
    w[1*19 +: 19] = {1'b0, 6'b000011, 12'($urandom())};
    w[0*19 +: 19] = {1'b0, 6'b000000, 12'($urandom())};
    fifo[5].push_back(w);
    run_pass("capture", 1'b0);

    // Saturation: 512 valid moves against a limit of 255
    clear_fifos();
    for (int i = 0; i < NSRC; i++) fifo[i].push_back(gen_word(8'hFF));
    run_pass("sat", 1'b0);

    // Reset in the middle of an emission
    clear_fifos();
    fifo[2].push_back(gen_word(8'hFF));
    build_model();
    repeat (2) @(posedge clk);
    #1; start = 1'b1;
    @(posedge clk);
    #1; start = 1'b0;
    cyc = 0;
    while (!mvValid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst_reach_emit", 32'(mvValid), 32'd1);
    @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk);
    #1;
    check_outputs_zero("midrst");
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear_fifos();
    exp_q.delete();

    // Fresh random passes, with random back-pressure
    rdy_rand = 1'b1;
    for (int p = 0; p < 4; p++) begin
      clear_fifos();
      for (int i = 0; i < NSRC; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          int n = $urandom_range(1, 2);
          for (int j = 0; j < n; j++) fifo[i].push_back(gen_word(8'($urandom_range(0, 255))));
        end
      end
      run_pass("rand", 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global bound on simulation length
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/move_collector.md
Name: move_collector

Overview:
- Downstream stage of the 64 per-square move generators.
- Once every square reports done, it drains each square's move FIFO in square order and unpacks each 152-bit word into eight 19-bit move slots.
- It discards invalid slots and streams the valid moves over a valid/ready interface to the move-list/search stage.
- It counts emitted moves, and saturates with a sticky overflow flag.

Parameters:
- NSRC, 64, number of square units drained; index width is clog2(NSRC).
- MAXMOVES, 255, maximum moves emitted per scan; must fit in 8 bits.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse that begins a collection pass
- sqDone  in  NSRC  done flags from the square units
- sqEmpty  in  NSRC  FIFO empty flags from the square units
- sqData  in  NSRC*152  FIFO q outputs; square i occupies bits [152i+151:152i]
- sqRden  out  NSRC  FIFO read requests, one-hot or zero
- mvValid  out  1  move available on mvData
- mvData  out  19  move word: [7b flag][6b from][6b to]
- mvReady  in  1  consumer accepts the move
- mvCount  out  8  moves emitted this pass
- busy  out  1  high in any state except IDLE and DONE
- done  out  1  high in DONE
- overflow  out  1  sticky: a valid move was dropped at MAXMOVES

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - Reset at any time, including mid-pass: state=IDLE, idx=0, slot=7, word=0, mvCount=0, overflow=0.
  - Reset values of outputs: all outputs 0.
- Flag layout: [18 invalid][17 promote][16 pawn][15 pawn2][14 enpassant][13 castle][12 capture]. A slot is invalid when bit 18 is 1.
- Slot order: slot k = word[19k+18:19k]. Slots are emitted from 7 down to 0 (MSB first).
- IDLE:
  - start=1 -> WAIT; clear mvCount, overflow, idx.
  - start is ignored in WAIT, SCAN, LAT and EMIT.
- WAIT: &sqDone -> SCAN. Otherwise stay in WAIT indefinitely.
- SCAN: one cycle per visit.
  - sqEmpty[idx]=0: sqRden[idx]=1 combinationally in this cycle -> LAT.
  - sqEmpty[idx]=1, idx=NSRC-1: -> DONE.
  - sqEmpty[idx]=1, idx<NSRC-1: idx+1, stay in SCAN.
- LAT: word <= sqData slice for idx (FIFO q is valid the cycle after rdreq); slot=7 -> EMIT.
- EMIT (one slot examined per cycle):
  - Invalid slot: skipped in 1 cycle; mvValid=0.
  - Valid slot, mvCount<MAXMOVES: mvValid=1 and mvData=slot, held stable until mvReady. On a cycle with mvValid&mvReady, mvCount+1 and the slot advances.
  - Valid slot, mvCount=MAXMOVES: mvValid stays 0, overflow<=1, slot advances in 1 cycle.
  - After slot 0 is finished -> SCAN with the same idx, so the same square's further FIFO words are drained before moving on.
- DONE:
  - done=1; mvCount and overflow are held.
  - start -> WAIT with counters cleared.
- Output timing:
  - mvData=0 whenever mvValid=0.
  - mvValid is never asserted outside EMIT.
  - sqRden is never asserted outside SCAN.
- Latency:
  - Per FIFO word: 2 cycles plus 8 slot cycles, assuming mvReady is held high.
  - Per empty square: 1 cycle.
- A word with all 8 slots invalid is legal: 8 silent cycles, no emission.

Optional Feature:
- Macro: MVC_CAPTURE_STATS_EN.
- Defined: adds output capCount (8 bits). It increments on each accepted move whose bit 12 is 1, saturates at 255, and clears on reset and on start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Single move: all sqEmpty=1 except square 12, whose one word has only slot 3 valid (0x0_0A1C, from 050 to 034) -> exactly one mvValid beat with mvData=0x00A1C; mvCount=1; DONE reached after the remaining scan.
- Back-pressure: square 0 word with slots 7 and 5 valid, mvReady low 4 cycles -> mvData stable throughout; emission order is slot 7 then slot 5; mvCount=2.
- Multi-word drain: square 63 FIFO holds 2 words of 8 valid moves each -> 16 beats, sqRden[63] pulsed twice, mvCount=16, done=1.
- Wait gating: start with sqDone=0xFFFF_FFFF_FFFF_FFFE -> stays in WAIT with sqRden=0; set bit 0 -> scan begins next cycle.
- Saturation: MAXMOVES=4, 6 valid moves supplied -> 4 beats, overflow=1, mvCount=4, DONE still reached.
- Reset mid-EMIT while mvValid=1 -> next cycle all outputs 0, state IDLE; a fresh start completes normally. With MVC_CAPTURE_STATS_EN, 3 capture-flagged moves give capCount=3.
